// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address helpers for the cache miss-fill engine.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH        = 16;
  localparam int unsigned DATA_WIDTH        = 16;
  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;

  // issue_cnt must reach WORDS_PER_BLOCK; recv_cnt only needs WORDS_PER_BLOCK-1.
  localparam int unsigned ISSUE_CNT_W = $clog2(WORDS_PER_BLOCK + 1);
  localparam int unsigned RECV_CNT_W  = $clog2(WORDS_PER_BLOCK);

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } fill_state_e;

  function automatic logic [ADDR_WIDTH-1:0] block_align(input logic [ADDR_WIDTH-1:0] addr);
    return {addr[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
  endfunction

  // Word idx of the block at base; the offset is truncated so it never carries into the tag.
  function automatic logic [ADDR_WIDTH-1:0] block_word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                            input logic [ISSUE_CNT_W-1:0] idx);
    logic [BLOCK_OFFSET_BITS-1:0] off;
    off = BLOCK_OFFSET_BITS'({idx, 1'b0});
    return {base[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], off};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of cache-side miss signals, memory read port and cache array write port.
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  fsm_busy;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic                  memory_data_valid;
  logic [DATA_WIDTH-1:0] memory_data;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [ADDR_WIDTH-1:0] fill_address;
  logic [DATA_WIDTH-1:0] fill_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array,
           fill_address, fill_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_read_en, memory_address, write_data_array, write_tag_array,
           fill_address, fill_data
  );

endinterface

// File: rtl/fill_counter.sv
// Up-counter with enable and synchronous clear; clear wins over enable.
module fill_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill engine: stalls the pipeline, streams one block from pipelined memory into the
// cache data array and writes tag/valid together with the last word.
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ISSUE_CNT_W-1:0] issue_cnt;
  logic [RECV_CNT_W-1:0]  recv_cnt;

  logic busy, issue_en, recv_en, last_word, cnt_clr;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    busy      = 1'b0;
    issue_en  = 1'b0;
    recv_en   = 1'b0;
    last_word = 1'b0;
    cnt_clr   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stall in the miss cycle itself; returning data is ignored here.
        busy    = bus.miss_detected;
        cnt_clr = 1'b1;
        if (bus.miss_detected) begin
          base_d  = block_align(bus.miss_address);
          state_d = StFill;
        end
      end
      StFill: begin
        busy      = 1'b1;
        issue_en  = issue_cnt < ISSUE_CNT_W'(WORDS_PER_BLOCK);
        recv_en   = bus.memory_data_valid;
        last_word = bus.memory_data_valid && (recv_cnt == RECV_CNT_W'(WORDS_PER_BLOCK - 1));
        if (last_word) begin
          cnt_clr = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  fill_counter #(
    .Width (ISSUE_CNT_W)
  ) u_issue_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (cnt_clr),
    .en_i    (issue_en),
    .count_o (issue_cnt)
  );

  fill_counter #(
    .Width (RECV_CNT_W)
  ) u_recv_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (cnt_clr),
    .en_i    (recv_en),
    .count_o (recv_cnt)
  );

  assign bus.fsm_busy         = busy;
  assign bus.mem_read_en      = issue_en;
  assign bus.memory_address   = block_word_addr(base_q, issue_cnt);
  assign bus.write_data_array = recv_en;
  assign bus.write_tag_array  = last_word;
  assign bus.fill_address     = block_word_addr(base_q, ISSUE_CNT_W'(recv_cnt));
  assign bus.fill_data        = bus.memory_data;

endmodule
